processor_sequencer: RTL and testbench

PROCESSOR_SEQUENCER -- requirements
Module: processor_sequencer

---
 rtl/processor_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_processor_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_sequencer.sv
// Purpose : drives a soft processor through load -> run -> register dump -> finish.
// Latency : start to done = prog_len load beats + max(1,run_cycles) + 2/set mask bit + 1 + 1 cycles.
// Backpr. : the instruction stream stalls on ld_valid=0; run and dump phases never stall.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   start               begin a sequence (only honoured in IDLE)
//   prog_len            instruction words to load (latched at start)
//   run_cycles          cycles to hold working high (latched at start)
//   dump_mask           registers r0..r15 to read back (latched at start)
//   ld_valid/ld_ready/ld_data   instruction-word stream in
//   addr/wEn/wDat       processor instruction-memory write port
//   working             processor run enable
//   rID/rdata           processor register read port
//   res_valid/res_id/res_data   dump results, held between pulses
//   busy, done          not-idle flag, one-cycle completion pulse
module processor_sequencer #(
    parameter int PC_W  = 9,
    parameter int RUN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  prog_len,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [15:0]      dump_mask,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_data,
    output logic [PC_W-1:0]  addr,
    output logic             wEn,
    output logic [31:0]      wDat,
    output logic             working,
    output logic [3:0]       rID,
    input  logic [31:0]      rdata,
    output logic             res_valid,
    output logic [3:0]       res_id,
    output logic [31:0]      res_data,
    output logic             busy,
    output logic             done
);

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    // Sequence parameters captured at start.
    logic [PC_W-1:0]  len_q;
    logic [RUN_W-1:0] run_q;
    // Registers still to be dumped; a bit is cleared when its visit completes.
    logic [15:0]      pend_q;

    logic [PC_W-1:0]  ld_cnt;
    logic [RUN_W-1:0] run_cnt;
    // 0 = first cycle of a register visit, 1 = second (capture) cycle.
    logic             phase_q;

    logic             res_valid_q;
    logic [3:0]       res_id_q;
    logic [31:0]      res_data_q;

    logic [3:0]       visit_idx;
    logic             run_last;

    // Lowest pending register index: the scan runs high-to-low so the last
    // hit, i.e. the smallest index, wins.
    always_comb begin
        visit_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_q[i]) begin
                visit_idx = 4'(i);
            end
        end
    end

    // A zero run length still spends one cycle in RUN, just without working.
    assign run_last = (run_q == '0) || (run_cnt == run_q - RUN_ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        wEn       = 1'b0;
        addr      = '0;
        wDat      = '0;
        working   = 1'b0;
        rID       = '0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (prog_len == '0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                wEn      = ld_valid;
                addr     = ld_cnt;
                wDat     = ld_data;
                if (ld_valid && (ld_cnt == len_q - PC_ONE)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                working = (run_q != '0);
                if (run_last) begin
                    state_nxt = S_DUMP;
                end
            end
            S_DUMP: begin
                // An empty pending set costs one DUMP cycle before FIN, so
                // done trails the final result pulse by one cycle.
                if (pend_q == '0) begin
                    state_nxt = S_FIN;
                end else begin
                    rID = visit_idx;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_q       <= '0;
            run_q       <= '0;
            pend_q      <= '0;
            ld_cnt      <= '0;
            run_cnt     <= '0;
            phase_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q   <= prog_len;
                        run_q   <= run_cycles;
                        pend_q  <= dump_mask;
                        ld_cnt  <= '0;
                        run_cnt <= '0;
                        phase_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        ld_cnt <= ld_cnt + PC_ONE;
                    end
                end
                S_RUN: begin
                    run_cnt <= run_cnt + RUN_ONE;
                end
                S_DUMP: begin
                    if (pend_q != '0) begin
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                        end else begin
                            // rID has been stable for two cycles; take the
                            // read data and retire this register.
                            phase_q           <= 1'b0;
                            res_valid_q       <= 1'b1;
                            res_id_q          <= visit_idx;
                            res_data_q        <= rdata;
                            pend_q[visit_idx] <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_processor_sequencer.sv
module tb_processor_sequencer;

    localparam int PC_W  = 9;
    localparam int RUN_W = 16;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DUMP = 3;
    localparam int PH_FIN  = 4;

    logic             clock;
    logic             reset;
    logic             start;
    logic [PC_W-1:0]  prog_len;
    logic [RUN_W-1:0] run_cycles;
    logic [15:0]      dump_mask;
    logic             ld_valid;
    logic             ld_ready;
    logic [31:0]      ld_data;
    logic [PC_W-1:0]  addr;
    logic             wEn;
    logic [31:0]      wDat;
    logic             working;
    logic [3:0]       rID;
    logic [31:0]      rdata;
    logic             res_valid;
    logic [3:0]       res_id;
    logic [31:0]      res_data;
    logic             busy;
    logic             done;

    processor_sequencer #(.PC_W(PC_W), .RUN_W(RUN_W)) dut (
        .clock(clock), .reset(reset), .start(start),
        .prog_len(prog_len), .run_cycles(run_cycles), .dump_mask(dump_mask),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .addr(addr), .wEn(wEn), .wDat(wDat),
        .working(working), .rID(rID), .rdata(rdata),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .busy(busy), .done(done)
    );

    // Processor register file stand-in: register n reads as 0x100 + n.
    assign rdata = 32'h100 + {28'h0, rID};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: phase, words still owed, run cycles left, and the
    // ordered list of registers still to read back.
    int          m_ph       = PH_IDLE;
    bit          m_on       = 1'b0;
    int          m_plen     = 0;
    int          m_loaded   = 0;
    int          m_run_left = 0;
    int          m_age      = 0;
    int          m_q[$];
    logic        m_rv       = 1'b0;
    logic [3:0]  m_rid      = '0;
    logic [31:0] m_rdat     = '0;

    // Observations of the current sequence.
    int          wr_cnt, work_cnt, gap_cnt, gap_bad, max_addr, done_cyc, start_cyc;
    bit          done_seen;
    logic [31:0] mem [0:511];
    int          res_ids[$];
    logic [31:0] res_dat[$];
    int          res_cyc[$];

    function automatic logic [31:0] wordv(input int i);
        case (i)
            0:  return 32'h10f00001;
            1:  return 32'h10f00093;
            2:  return 32'h20100113;
            3:  return 32'h20200193;
            4:  return 32'h30308233;
            5:  return 32'h304102b3;
            6:  return 32'h30518333;
            7:  return 32'h306203b3;
            8:  return 32'h40328433;
            9:  return 32'h404304b3;
            10: return 32'h40538533;
            11: return 32'h40500067;
            default: return 32'h5a000000 ^ 32'(i * 65537);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        cyc++;
        if (reset) begin
            m_on       = 1'b1;
            m_ph       = PH_IDLE;
            m_rv       = 1'b0;
            m_rid      = '0;
            m_rdat     = '0;
            m_loaded   = 0;
            m_run_left = 0;
            m_age      = 0;
            m_q.delete();
        end else begin
            m_rv = 1'b0;
            case (m_ph)
                PH_IDLE: if (start) begin
                    m_plen     = int'(prog_len);
                    m_run_left = int'(run_cycles);
                    m_loaded   = 0;
                    m_age      = 0;
                    m_q.delete();
                    for (int i = 0; i < 16; i++) if (dump_mask[i]) m_q.push_back(i);
                    m_ph = (m_plen == 0) ? PH_RUN : PH_LOAD;
                end
                PH_LOAD: if (ld_valid) begin
                    m_loaded++;
                    if (m_loaded == m_plen) m_ph = PH_RUN;
                end
                PH_RUN: begin
                    if (m_run_left <= 1) m_ph = PH_DUMP;
                    else m_run_left--;
                end
                PH_DUMP: begin
                    if (m_q.size() == 0) m_ph = PH_FIN;
                    else if (m_age == 0) m_age = 1;
                    else begin
                        m_rv   = 1'b1;
                        m_rid  = 4'(m_q[0]);
                        m_rdat = 32'h100 + 32'(m_q[0]);
                        void'(m_q.pop_front());
                        m_age  = 0;
                    end
                end
                default: m_ph = PH_IDLE;
            endcase
        end
    endtask

    task automatic compare_and_record();
        int exp_rid;
        if (m_on) begin
            exp_rid = 0;
            if (m_ph == PH_DUMP && m_q.size() > 0) exp_rid = m_q[0];
            chk("busy",      64'(busy),      64'(m_ph != PH_IDLE));
            chk("done",      64'(done),      64'(m_ph == PH_FIN));
            chk("ld_ready",  64'(ld_ready),  64'(m_ph == PH_LOAD));
            chk("wEn",       64'(wEn),       64'(m_ph == PH_LOAD && ld_valid));
            chk("addr",      64'(addr),      64'((m_ph == PH_LOAD) ? m_loaded : 0));
            chk("wDat",      64'(wDat),      64'((m_ph == PH_LOAD) ? ld_data : 32'h0));
            chk("working",   64'(working),   64'(m_ph == PH_RUN && m_run_left != 0));
            chk("rID",       64'(rID),       64'(exp_rid));
            chk("res_valid", 64'(res_valid), 64'(m_rv));
            chk("res_id",    64'(res_id),    64'(m_rid));
            chk("res_data",  64'(res_data),  64'(m_rdat));
        end
        if (wEn === 1'b1) begin
            wr_cnt++;
            mem[addr] = wDat;
            if (int'(addr) > max_addr) max_addr = int'(addr);
        end
        if (working === 1'b1) work_cnt++;
        if (res_valid === 1'b1) begin
            res_ids.push_back(int'(res_id));
            res_dat.push_back(res_data);
            res_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (ld_ready === 1'b1 && ld_valid === 1'b0) begin
            gap_cnt++;
            if (addr !== 9'd5) gap_bad++;
        end
    endtask

    // One clock cycle: outputs compared at the falling edge, model advanced
    // on the rising edge, inputs free to change 1 time unit later.
    task automatic step();
        @(negedge clock);
        compare_and_record();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // Runs one sequence. gap_at/gap_n withhold ld_valid before word gap_at;
    // xstart_off re-pulses start that many cycles after the first start;
    // rst_after asserts reset once that many working cycles have been seen.
    task automatic run_seq(input int plen, input int rc, input logic [15:0] mask,
                           input int gap_at, input int gap_n, input int xstart_off,
                           input int rst_after);
        int idx, gaps, n;
        bit hs, aborted;
        wr_cnt = 0; work_cnt = 0; gap_cnt = 0; gap_bad = 0; max_addr = 0;
        done_seen = 1'b0; done_cyc = 0;
        res_ids.delete(); res_dat.delete(); res_cyc.delete();
        idx = 0; gaps = 0; n = 0; aborted = 1'b0;
        start_cyc = cyc;
        while (!done_seen && n < 2000) begin
            if (n == 0) begin
                start      = 1'b1;
                prog_len   = PC_W'(plen);
                run_cycles = RUN_W'(rc);
                dump_mask  = mask;
            end else begin
                // Scrambled inputs show the sequence runs on latched values.
                start      = (n == xstart_off);
                prog_len   = 9'd3;
                run_cycles = 16'd1;
                dump_mask  = 16'hffff;
            end
            if (idx < plen && !(idx == gap_at && gaps < gap_n)) begin
                ld_valid = 1'b1;
                ld_data  = wordv(idx);
            end else begin
                if (idx == gap_at && gaps < gap_n) gaps++;
                ld_valid = 1'b0;
                ld_data  = 32'hdeadbeef;
            end
            hs = ld_valid && ld_ready;
            step();
            if (hs) idx++;
            n++;
            if (rst_after >= 0 && work_cnt == rst_after) begin
                reset    = 1'b1;
                ld_valid = 1'b0;
                start    = 1'b0;
                step();
                aborted = 1'b1;
                break;
            end
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        if (!aborted) chk("done_within_budget", 64'(done_seen), 64'd1);
    endtask

    task automatic check_main_seq(input string tag);
        chk({tag, "_wr_count"}, 64'(wr_cnt), 64'd12);
        for (int i = 0; i < 12; i++) chk({tag, "_word"}, 64'(mem[i]), 64'(wordv(i)));
        chk({tag, "_working_cycles"}, 64'(work_cnt), 64'd20);
        chk({tag, "_res_count"}, 64'(res_ids.size()), 64'd3);
        if (res_ids.size() == 3) begin
            chk({tag, "_res0_id"}, 64'(res_ids[0]), 64'd3);
            chk({tag, "_res1_id"}, 64'(res_ids[1]), 64'd4);
            chk({tag, "_res2_id"}, 64'(res_ids[2]), 64'd5);
            chk({tag, "_res2_data"}, 64'(res_dat[2]), 64'h105);
        end
        chk({tag, "_done_offset"}, 64'(done_cyc - start_cyc), 64'd40);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_len = '0; run_cycles = '0; dump_mask = '0;
        ld_valid = 1'b0; ld_data = '0;
        #1;
        repeat (3) step();
        chk("reset_outputs_ctl",
            64'({ld_ready, wEn, addr, working, rID, res_valid, res_id, busy, done}), 64'd0);
        chk("reset_outputs_dat", {wDat, res_data}, 64'd0);
        reset = 1'b0;
        step();

        // Main sequence: 12 words, 20 run cycles, dump r3..r5.
        run_seq(12, 20, 16'h0038, -1, 0, -1, -1);
        check_main_seq("main");
        step();

        // Dump of r0 and r15 only.
        run_seq(2, 3, 16'h8001, -1, 0, -1, -1);
        chk("m8001_res_count", 64'(res_ids.size()), 64'd2);
        if (res_ids.size() == 2) begin
            chk("m8001_res0_id",   64'(res_ids[0]), 64'd0);
            chk("m8001_res0_data", 64'(res_dat[0]), 64'h100);
            chk("m8001_res1_id",   64'(res_ids[1]), 64'd15);
            chk("m8001_res1_data", 64'(res_dat[1]), 64'h10f);
            chk("m8001_res_spacing", 64'(res_cyc[1] - res_cyc[0]), 64'd2);
            chk("m8001_done_after_res", 64'(done_cyc - res_cyc[1]), 64'd1);
        end
        chk("m8001_done_offset", 64'(done_cyc - start_cyc), 64'd11);

        // Stream stalls for 3 cycles after word 4.
        run_seq(12, 4, 16'h0002, 5, 3, -1, -1);
        chk("gap_cycles", 64'(gap_cnt), 64'd3);
        chk("gap_addr_not_5", 64'(gap_bad), 64'd0);
        chk("gap_wr_count", 64'(wr_cnt), 64'd12);
        chk("gap_word5", 64'(mem[5]), 64'(wordv(5)));
        chk("gap_word11", 64'(mem[11]), 64'(wordv(11)));
        chk("gap_done_offset", 64'(done_cyc - start_cyc), 64'd23);

        // Everything zero: IDLE -> RUN -> DUMP -> FIN.
        run_seq(0, 0, 16'h0000, -1, 0, -1, -1);
        chk("zero_done_offset", 64'(done_cyc - start_cyc), 64'd3);
        chk("zero_wr_count", 64'(wr_cnt), 64'd0);
        chk("zero_working", 64'(work_cnt), 64'd0);
        chk("zero_res_count", 64'(res_ids.size()), 64'd0);

        // Reset lands at the end of RUN cycle 7.
        run_seq(1, 20, 16'h0001, -1, 0, -1, 6);
        chk("rst_working_cycles", 64'(work_cnt), 64'd7);
        chk("rst_working_after", 64'(working), 64'd0);
        chk("rst_busy_after", 64'(busy), 64'd0);
        chk("rst_wen_after", 64'(wEn), 64'd0);
        step();
        reset = 1'b0;
        step();
        run_seq(12, 20, 16'h0038, -1, 0, -1, -1);
        check_main_seq("after_rst");
        step();

        // Extra start pulse while running is ignored.
        run_seq(12, 20, 16'h0038, -1, 0, 20, -1);
        check_main_seq("start_in_run");
        step();

        // Longest program: addresses 0..510, no wrap.
        run_seq(511, 1, 16'h0000, -1, 0, -1, -1);
        chk("long_wr_count", 64'(wr_cnt), 64'd511);
        chk("long_max_addr", 64'(max_addr), 64'd510);
        chk("long_word0", 64'(mem[0]), 64'(wordv(0)));
        chk("long_word510", 64'(mem[510]), 64'(wordv(510)));
        chk("long_done_offset", 64'(done_cyc - start_cyc), 64'd514);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
